// File: rtl/mux_n_1_rr.sv
// mux_n_1_rr: N:1 channel multiplexer with valid/ready handshakes on every
// channel and on the output, round-robin arbitration between requesters and
// a single registered output stage that behaves as a 1-deep pipeline.
//
// Optional feature: define MUX_LOCK_EN to add in_last/out_last and packet
// locking. Once a channel is granted a beat that is not its last, that
// channel keeps the output until its last beat is accepted. Without the
// macro every beat is arbitrated independently.
module mux_n_1_rr #(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_sel
`ifdef MUX_LOCK_EN
    ,
    input  logic [N-1:0]    in_last,
    output logic            out_last
`endif
);

    // Output stage state.
    logic [W-1:0]    out_data_q;
    logic            out_valid_q;
    logic [SELW-1:0] out_sel_q;

    // Round-robin pointer: the first channel to consider on the next grant.
    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] ptr_d;

    // Arbitration results.
    logic            load;
    logic            found;
    logic [SELW-1:0] gnt;
    logic            accept;
    logic [N-1:0]    elig;
    logic [W-1:0]    gnt_data;

`ifdef MUX_LOCK_EN
    logic            lock_q;
    logic [SELW-1:0] locked_q;
    logic            out_last_q;
    logic            gnt_last;
`endif

    // Search elig starting at ptr and wrapping N-1 -> 0. Returns {found, index}.
    // The sum is kept one bit wider than the index so the wrap also works when
    // N is not a power of two.
    function automatic logic [SELW:0] rr_pick(input logic [N-1:0]    e,
                                              input logic [SELW-1:0] p);
        logic            hit;
        logic [SELW-1:0] idx;
        logic [SELW:0]   sum;
        logic [SELW-1:0] c;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, p} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(N)) begin
                sum = sum - (SELW+1)'(N);
            end
            c = sum[SELW-1:0];
            if (!hit && e[c]) begin
                hit = 1'b1;
                idx = c;
            end
        end
        return {hit, idx};
    endfunction

    // Pointer value following a grant to channel g (wraps to 0 after N-1).
    function automatic logic [SELW-1:0] rr_next(input logic [SELW-1:0] g);
        if (g == SELW'(N - 1)) begin
            return '0;
        end
        return g + SELW'(1);
    endfunction

    // The output register may take a new word when it is empty or being drained.
    assign load = ~out_valid_q | out_ready;

    // Eligible channels: all requesters, or only the locked channel mid-packet.
    always_comb begin
        elig = in_valid;
`ifdef MUX_LOCK_EN
        if (lock_q) begin
            for (int i = 0; i < N; i++) begin
                elig[i] = in_valid[i] & (locked_q == SELW'(i));
            end
        end
`endif
    end

    // Pick the granted channel and steer its data (and last flag) to the output stage.
    always_comb begin
        {found, gnt} = rr_pick(elig, ptr_q);
        gnt_data     = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = in_data[i*W +: W];
            end
        end
`ifdef MUX_LOCK_EN
        gnt_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_last = in_last[i];
            end
        end
`endif
    end

    // One-hot ready to the granted channel only; held low during reset and stalls.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = load & found & ~rst & (gnt == SELW'(i));
        end
    end

    assign accept = load & found;
    assign ptr_d  = rr_next(gnt);

    // Output register, round-robin pointer and packet lock update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef MUX_LOCK_EN
            lock_q      <= 1'b0;
            locked_q    <= '0;
            out_last_q  <= 1'b0;
`endif
        end else if (load) begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= gnt_data;
                out_sel_q   <= gnt;
                ptr_q       <= ptr_d;
`ifdef MUX_LOCK_EN
                out_last_q  <= gnt_last;
                // While locked the grant can only be locked_q, so this both
                // opens a new packet and keeps an open one; the last beat releases it.
                if (!gnt_last) begin
                    lock_q   <= 1'b1;
                    locked_q <= gnt;
                end else begin
                    lock_q   <= 1'b0;
                end
`endif
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
`ifdef MUX_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule
